// File: rtl/pontuacao_seq.sv
// rtl/pontuacao_seq.sv - sequential score unit: (level+1[+map]) x round via shift-add, saturation, high score
module pontuacao_seq #(
  parameter int P_ROUND      = 4,
  parameter int P_SETUP      = 2,
  parameter int P_POINTS     = 8,
  parameter int MAP_BONUS_EN = 0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [P_ROUND-1:0]  round,
  input  logic [P_SETUP-1:0]  reg_setup_level,
  input  logic [P_SETUP-1:0]  reg_setup_mapa,
  input  logic                clear_high,
  output logic                busy,
  output logic                done,
  output logic [P_POINTS-1:0] points,
  output logic                overflow,
  output logic [P_POINTS-1:0] high_score,
  output logic                new_record
);

  localparam int MC_W   = P_SETUP + 2;
  localparam int ACC_W  = P_ROUND + P_SETUP + 2;
  localparam int STEP_W = $clog2(P_ROUND + 1);
  localparam int CW     = (ACC_W > P_POINTS) ? ACC_W : P_POINTS;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_SAT,
    S_DONE
  } state_t;

  state_t              state_q,      state_d;
  logic [MC_W-1:0]     mcand_q,      mcand_d;
  logic [P_ROUND-1:0]  mplier_q,     mplier_d;
  logic [ACC_W-1:0]    acc_q,        acc_d;
  logic [STEP_W-1:0]   step_q,       step_d;
  logic [P_POINTS-1:0] points_q,     points_d;
  logic                overflow_q,   overflow_d;
  logic [P_POINTS-1:0] high_q,       high_d;
  logic                new_rec_q,    new_rec_d;

  logic [MC_W-1:0]     mcand_in;
  logic [ACC_W-1:0]    partial;
  logic [CW-1:0]       acc_ext;
  logic [CW-1:0]       max_pts;
  logic                sat;
  logic [P_POINTS-1:0] sat_val;

  always_comb begin
    max_pts                = '0;
    max_pts[P_POINTS-1:0]  = '1;
  end

  always_comb begin
    mcand_in = MC_W'(reg_setup_level) + MC_W'(1);
    if (MAP_BONUS_EN != 0) begin
      mcand_in = mcand_in + MC_W'(reg_setup_mapa);
    end
    // Accumulator is wide enough for the full product, so only the final value is saturated.
    partial = mplier_q[0] ? (ACC_W'(mcand_q) << step_q) : '0;
    acc_ext = CW'(acc_q);
    sat     = acc_ext > max_pts;
    sat_val = sat ? '1 : acc_ext[P_POINTS-1:0];
  end

  always_comb begin
    state_d    = state_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    acc_d      = acc_q;
    step_d     = step_q;
    points_d   = points_q;
    overflow_d = overflow_q;
    high_d     = high_q;
    new_rec_d  = new_rec_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mcand_d   = mcand_in;
          mplier_d  = round;
          acc_d     = '0;
          step_d    = '0;
          new_rec_d = 1'b0;
          state_d   = S_MUL;
        end
      end
      S_MUL: begin
        acc_d    = acc_q + partial;
        mplier_d = mplier_q >> 1;
        step_d   = step_q + STEP_W'(1);
        if (step_q == STEP_W'(P_ROUND - 1)) begin
          state_d = S_SAT;
        end
      end
      S_SAT: begin
        points_d   = sat_val;
        overflow_d = sat;
        new_rec_d  = 1'b0;
        if (sat_val > high_q) begin
          high_d    = sat_val;
          new_rec_d = 1'b1;
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A clear on the SAT edge overrides any record just set.
    if (clear_high) begin
      high_d = '0;
      if (state_q == S_SAT) begin
        new_rec_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      mcand_q    <= '0;
      mplier_q   <= '0;
      acc_q      <= '0;
      step_q     <= '0;
      points_q   <= '0;
      overflow_q <= 1'b0;
      high_q     <= '0;
      new_rec_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      acc_q      <= acc_d;
      step_q     <= step_d;
      points_q   <= points_d;
      overflow_q <= overflow_d;
      high_q     <= high_d;
      new_rec_q  <= new_rec_d;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign points     = points_q;
  assign overflow   = overflow_q;
  assign high_score = high_q;
  assign new_record = new_rec_q;

endmodule
